// File: rtl/cam_cfg_pkg.sv
// Shared types, SCCB framing constants and the OV7670 register table
// used by the camera configuration sequencer.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HW_RESET,
    ST_SETTLE,
    ST_FETCH,
    ST_WRITE,
    ST_GAP,
    ST_DELAY,
    ST_DONE
  } state_t;

  // Table entries are {reg, val}; these two codes are reserved markers.
  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hF0F0;

  localparam int CFG_LEN   = 7;
  localparam int CFG_IDX_W = (CFG_LEN > 1) ? $clog2(CFG_LEN) : 1;

  localparam logic [15:0] CFG_ROM [CFG_LEN] = '{
    16'h1280,   // COM7: register reset
    CFG_DELAY,  // camera needs time to come out of its soft reset
    16'h1204,   // COM7: RGB output
    16'h40D0,   // COM15: RGB565, full range
    16'h8C00,   // RGB444 off
    16'h3A04,   // TSLB
    CFG_END
  };

  // SCCB 3-phase write: START, 27 bit slots of 4 quarters, STOP.
  localparam int SCCB_FRAME_BITS     = 27;
  localparam int SCCB_START_QUARTERS = 2;
  localparam int SCCB_STOP_QUARTERS  = 4;
  localparam int SCCB_QUARTERS       = SCCB_START_QUARTERS + 4 * SCCB_FRAME_BITS
                                       + SCCB_STOP_QUARTERS;
  localparam int SCCB_STOP_FIRST     = SCCB_QUARTERS - SCCB_STOP_QUARTERS;

  // Running off the end of the table behaves exactly like an END entry.
  function automatic logic [15:0] cfg_entry(input logic [5:0] idx);
    if (idx >= 6'(CFG_LEN)) return CFG_END;
    return CFG_ROM[idx[CFG_IDX_W-1:0]];
  endfunction

  // The ninth bit of each phase is the don't-care slot where the bus is released.
  function automatic logic sccb_is_dont_care(input logic [4:0] slot);
    return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  endfunction

endpackage

// File: rtl/cam_config_seq_sccb.sv
// Quarter-timed SCCB 3-phase write master: START, ID/reg/val with don't-care
// slots, STOP. A done pulse marks the last cycle of the final STOP quarter.
module sccb_write_master
  import cam_cfg_pkg::*;
#(
  parameter int QUARTER = 163
) (
  input  logic       clk_65mhz,
  input  logic       reset_n,
  input  logic       go_in,
  input  logic [7:0] id_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  output logic       sioc_out,
  output logic       siod_out,
  output logic       siod_oe_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam int             QW           = $clog2(QUARTER + 1);
  localparam logic [QW-1:0]  Q_LAST       = QW'(QUARTER - 1);
  localparam logic [6:0]     LAST_QUARTER = 7'(SCCB_QUARTERS - 1);
  localparam logic [6:0]     STOP_FIRST   = 7'(SCCB_STOP_FIRST);

  logic          busy;
  logic [QW-1:0] qcnt;
  logic [6:0]    quarter;
  logic [27:0]   frame;     // bit 27 is the low level left on siod by START
  logic          q_end;
  logic [6:0]    bit_q;
  logic [4:0]    slot;
  logic [1:0]    phase;
  logic [4:0]    cur_bit;
  logic [4:0]    prev_bit;

  assign q_end    = (qcnt == Q_LAST);
  assign bit_q    = quarter - 7'(SCCB_START_QUARTERS);
  assign slot     = bit_q[6:2];
  assign phase    = bit_q[1:0];
  assign cur_bit  = 5'(SCCB_FRAME_BITS - 1) - slot;
  assign prev_bit = cur_bit + 5'd1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      qcnt    <= '0;
      quarter <= '0;
      // NOTE: the frame register is reset as well so siod is deterministic straight out of reset.
      frame   <= '0;
    end else if (!busy) begin
      if (go_in) begin
        busy    <= 1'b1;
        qcnt    <= '0;
        quarter <= '0;
        frame   <= {1'b0, id_in, 1'b1, addr_in, 1'b1, data_in, 1'b1};
      end
    end else if (q_end) begin
      qcnt <= '0;
      if (quarter == LAST_QUARTER) busy <= 1'b0;
      else                         quarter <= quarter + 7'd1;
    end else begin
      qcnt <= qcnt + QW'(1);
    end
  end

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    sioc_out    = 1'b1;
    siod_out    = 1'b1;
    siod_oe_out = 1'b0;
    if (busy) begin
      siod_oe_out = 1'b1;
      if (quarter < 7'(SCCB_START_QUARTERS)) begin
        siod_out = (quarter == 7'd0);
      end else if (quarter < STOP_FIRST) begin
        // Data changes only in q1 while sioc is low; q0 keeps the previous bit.
        sioc_out = phase[1];
        if (phase == 2'd0) begin
          siod_out = frame[prev_bit];
        end else begin
          siod_out = frame[cur_bit];
          if (sccb_is_dont_care(slot)) siod_oe_out = 1'b0;
        end
      end else begin
        sioc_out = (quarter >= STOP_FIRST + 7'd2);
        siod_out = (quarter == LAST_QUARTER);
      end
    end
  end

  assign busy_out = busy;
  assign done_out = busy && q_end && (quarter == LAST_QUARTER);

endmodule

// File: rtl/cam_config_seq.sv
// OV7670 power-up sequencer: hardware reset pulse, settle wait, then walks the
// register table issuing SCCB writes; config_done_out gates the capture path.
module cam_config_seq
  import cam_cfg_pkg::*;
#(
  parameter int         QUARTER       = 163,
  parameter int         RESET_CYCLES  = 65000,
  parameter int         SETTLE_CYCLES = 65000,
  parameter int         DELAY_CYCLES  = 650000,
  parameter int         GAP_QUARTERS  = 8,
  parameter logic [7:0] DEV_ID        = 8'h42
) (
  input  logic       clk_65mhz,
  input  logic       reset_n,
  input  logic       start_in,
  output logic       sioc_out,
  output logic       siod_out,
  output logic       siod_oe_out,
  output logic       cam_rst_n_out,
  output logic       busy_out,
  output logic       config_done_out,
  output logic [5:0] entry_idx_out,
  output logic [7:0] write_count_out
);

  localparam int GAP_CYCLES = GAP_QUARTERS * QUARTER;
  localparam int MAX_A      = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B      = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
  localparam int MAX_WAIT   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W      = $clog2(MAX_WAIT + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_hit;
  logic [5:0]       entry_idx;
  logic [7:0]       write_count;
  logic [15:0]      entry;
  logic             is_end;
  logic             is_delay;
  logic             start_ok;
  logic             wr_go;
  logic             wr_done;
  logic             bus_own;
  logic             m_sioc;
  logic             m_siod;
  logic             m_oe;
  logic             m_busy;

  assign entry    = cfg_entry(entry_idx);
  assign is_end   = (entry == CFG_END);
  assign is_delay = (entry == CFG_DELAY);
  assign start_ok = start_in && (state == ST_IDLE || state == ST_DONE);

  always_comb begin
    cnt_limit = '0;
    case (state)
      ST_HW_RESET: cnt_limit = CNT_W'(RESET_CYCLES - 1);
      ST_SETTLE:   cnt_limit = CNT_W'(SETTLE_CYCLES - 1);
      ST_GAP:      cnt_limit = CNT_W'(GAP_CYCLES - 1);
      ST_DELAY:    cnt_limit = CNT_W'(DELAY_CYCLES - 1);
      default:     cnt_limit = '0;
    endcase
  end
  assign cnt_hit = (cnt == cnt_limit);

  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start_in) state_nxt = ST_HW_RESET;
      ST_HW_RESET: if (cnt_hit)  state_nxt = ST_SETTLE;
      ST_SETTLE:   if (cnt_hit)  state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (is_end)        state_nxt = ST_DONE;
        else if (is_delay) state_nxt = ST_DELAY;
        else               state_nxt = ST_WRITE;
      end
      ST_WRITE:    if (wr_done)  state_nxt = ST_GAP;
      ST_GAP:      if (cnt_hit)  state_nxt = ST_FETCH;
      ST_DELAY:    if (cnt_hit)  state_nxt = ST_FETCH;
      ST_DONE:     if (start_in) state_nxt = ST_HW_RESET;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cam_rst_n_out   = 1'b1;
    busy_out        = 1'b0;
    config_done_out = 1'b0;
    wr_go           = 1'b0;
    bus_own         = 1'b0;
    case (state)
      ST_HW_RESET: begin
        cam_rst_n_out = 1'b0;
        busy_out      = 1'b1;
      end
      ST_SETTLE: busy_out = 1'b1;
      ST_FETCH: begin
        busy_out = 1'b1;
        bus_own  = 1'b1;
        wr_go    = !is_end && !is_delay;
      end
      ST_WRITE, ST_GAP, ST_DELAY: begin
        busy_out = 1'b1;
        bus_own  = 1'b1;
      end
      ST_DONE:  config_done_out = 1'b1;
      default:  busy_out = 1'b0;
    endcase
  end

  // Every timed state starts its wait from zero on entry.
  always_ff @(posedge clk_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      entry_idx   <= '0;
      write_count <= '0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      if (start_ok) begin
        entry_idx   <= '0;
        write_count <= '0;
      end else begin
        if ((state == ST_WRITE && wr_done) || (state == ST_DELAY && cnt_hit))
          entry_idx <= entry_idx + 6'd1;
        if (state == ST_WRITE && wr_done && write_count != 8'hFF)
          write_count <= write_count + 8'd1;
      end
    end
  end

  sccb_write_master #(
    .QUARTER (QUARTER)
  ) u_sccb (
    .clk_65mhz   (clk_65mhz),
    .reset_n     (reset_n),
    .go_in       (wr_go),
    .id_in       (DEV_ID),
    .addr_in     (entry[15:8]),
    .data_in     (entry[7:0]),
    .sioc_out    (m_sioc),
    .siod_out    (m_siod),
    .siod_oe_out (m_oe),
    .busy_out    (m_busy),
    .done_out    (wr_done)
  );

  // Between transactions the sequencer holds the bus idle-high itself.
  assign sioc_out        = m_sioc;
  assign siod_out        = m_siod;
  assign siod_oe_out     = m_busy ? m_oe : bus_own;
  assign entry_idx_out   = entry_idx;
  assign write_count_out = write_count;

endmodule
